// File: rtl/sync_fifo_arb_pkg.sv
// Shared definitions for the sync_fifo write-port arbiter: FSM encoding and width helpers.
package sync_fifo_arb_pkg;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 1'b0;
  localparam arb_state_t ST_GRANT = 1'b1;

  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bcnt_w(input int mb);
    return $clog2(mb) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set, unmasked request after i_last, wrapping.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  input  logic [N-1:0]   i_mask,
  output logic           o_found,
  output logic [IDW-1:0] o_idx
);

  logic [N-1:0] w_req;
  int           w_dist;
  int           w_best;

  assign w_req = i_req & ~i_mask;

  // Distance 0 is the slot right after i_last; the nearest valid slot wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_best  = N;
    w_dist  = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - int'(i_last) - 1) % N;
      if (w_req[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_found = 1'b1;
        o_idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Burst-locked round-robin arbiter sharing one sync_fifo write port among NUM_REQ producers.
module sync_fifo_wr_arb
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4,
  localparam int GW        = gid_w(NUM_REQ),
  localparam int BW        = bcnt_w(MAX_BURST)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_data_in,
  output logic                          o_grant_valid,
  output logic [GW-1:0]                 o_grant_id
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_t    r_state;
  logic [GW-1:0] r_grant_id;
  logic [GW-1:0] r_last_id;
  logic [BW-1:0] r_beat_cnt;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_data;
  logic [NUM_REQ-1:0]                 w_own_oh;
  logic [NUM_REQ-1:0]                 w_mask;
  logic                               w_active;
  logic                               w_own_vld;
  logic                               w_beat;
  logic                               w_release;
  logic                               w_others;
  logic                               w_found;
  logic [GW-1:0]                      w_idx;

  assign w_data    = i_req_data;
  assign w_own_oh  = NUM_REQ'(1) << r_grant_id;
  // Gating with reset keeps an in-flight beat from being written at the reset edge.
  assign w_active  = (r_state == ST_GRANT) && !i_rst;
  assign w_own_vld = i_req_valid[r_grant_id];
  assign w_beat    = w_active && w_own_vld && !i_fifo_full;
  assign w_release = w_active && (!w_own_vld || (w_beat && (r_beat_cnt == LAST_BEAT)));
  assign w_others  = |(i_req_valid & ~w_own_oh);
  assign w_mask    = (w_release && w_others) ? w_own_oh : '0;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (GW)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_last  (r_last_id),
    .i_mask  (w_mask),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign o_req_ready    = (w_active && !i_fifo_full) ? w_own_oh : '0;
  assign o_fifo_wr_en   = w_beat;
  assign o_fifo_data_in = w_active ? w_data[r_grant_id] : '0;
  assign o_grant_valid  = w_active;
  assign o_grant_id     = r_grant_id;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_last_id  <= GW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_found) begin
        r_state    <= ST_GRANT;
        r_grant_id <= w_idx;
        r_last_id  <= w_idx;
        r_beat_cnt <= '0;
      end
    end else if (w_release) begin
      r_beat_cnt <= '0;
      if (w_found) begin
        r_grant_id <= w_idx;
        r_last_id  <= w_idx;
      end else begin
        r_state <= ST_IDLE;
      end
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Directed bench for sync_fifo_wr_arb with a per-cycle reference model and literal checkpoints.
module tb_sync_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  typedef struct packed {
    int own;
    int last;
    int cnt;
  } mst_t;

  typedef struct packed {
    logic [N-1:0]  rdy;
    logic          wr;
    logic [DW-1:0] d;
    logic          gv;
  } eout_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N*DW-1:0] data;
  logic            full;
  logic [N-1:0]    ready;
  logic            wr;
  logic [DW-1:0]   din;
  logic            gv;
  logic [1:0]      gid;

  int   errs   = 0;
  int   checks = 0;
  int   nwr;
  int   exp_seq [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
  mst_t ms = '{own: -1, last: N-1, cnt: 0};
  eout_t eo;

  sync_fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (valid),
    .i_req_data     (data),
    .o_req_ready    (ready),
    .i_fifo_full    (full),
    .o_fifo_wr_en   (wr),
    .o_fifo_data_in (din),
    .o_grant_valid  (gv),
    .o_grant_id     (gid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last, input int excl);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N] && ((last + k) % N) != excl) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic mst_t next_st(input mst_t s, input logic r, input logic [N-1:0] v,
                                   input logic f);
    mst_t n = s;
    bit   beat;
    int   ex;
    int   p;
    if (r) begin
      n.own = -1; n.last = N-1; n.cnt = 0;
    end else if (s.own < 0) begin
      p = pick(v, s.last, -1);
      if (p >= 0) begin n.own = p; n.last = p; n.cnt = 0; end
    end else begin
      beat = v[s.own] && !f;
      if (beat) n.cnt = s.cnt + 1;
      if (!v[s.own] || (beat && n.cnt == MB)) begin
        ex = ((v & ~(N'(1) << s.own)) != 0) ? s.own : -1;
        p  = pick(v, s.last, ex);
        if (p >= 0) begin n.own = p; n.last = p; n.cnt = 0; end
        else begin n.own = -1; n.cnt = 0; end
      end
    end
    return n;
  endfunction

  function automatic eout_t expect_out(input mst_t s, input logic r, input logic [N-1:0] v,
                                       input logic f, input logic [N*DW-1:0] dat);
    eout_t o = '0;
    if (!r && s.own >= 0) begin
      o.gv  = 1'b1;
      o.rdy = f ? '0 : (N'(1) << s.own);
      o.wr  = v[s.own] && !f;
      o.d   = dat[s.own*DW +: DW];
    end
    return o;
  endfunction

  always @(posedge clk) ms <= next_st(ms, rst, valid, full);

  assign eo = expect_out(ms, rst, valid, full, data);

  always @(negedge clk) begin
    chk("m_ready", ready, eo.rdy);
    chk("m_wr", wr, eo.wr);
    chk("m_data", din, eo.d);
    chk("m_gv", gv, eo.gv);
    if (eo.gv) chk("m_gid", gid, ms.own);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    valid = '0;
    full  = 1'b0;
    rst   = 1'b1;
    cyc();
    rst   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    valid = '1;
    full  = 1'b0;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'((i + 1) * 4096 + 165);

    // reset held with all requesters valid
    repeat (2) begin
      cyc(); #1;
      chk("rst_ready", ready, 0);
      chk("rst_wr", wr, 0);
      chk("rst_gv", gv, 0);
    end
    rst = 1'b0;
    cyc(); #1;
    chk("first_gid", gid, 0);
    chk("first_gv", gv, 1);

    // burst lock across all four requesters
    nwr = 0;
    for (int i = 0; i < 16; i++) begin
      chk("burst_gid", gid, exp_seq[i]);
      nwr += int'(wr);
      cyc(); #1;
    end
    chk("burst_writes", nwr, 16);

    // full stall on requester 2 after its first beat
    do_rst();
    valid = 4'b1100;
    cyc(); #1;
    chk("stall_gid0", gid, 2);
    chk("stall_beat1", wr, 1);
    chk("stall_data", din, 16'h30A5);
    cyc();
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_wr", wr, 0);
      chk("stall_ready", ready, 0);
      chk("stall_hold", gid, 2);
      if (k == 2) chk("stall_cnt", dut.r_beat_cnt, 1);
      cyc();
    end
    full = 1'b0;
    nwr  = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_gid", gid, 2);
      nwr += int'(wr);
      cyc();
    end
    #1;
    chk("stall_beats", nwr, 3);
    chk("stall_rot", gid, 3);

    // requester 1 drops after two beats, requester 3 waiting
    do_rst();
    valid = 4'b1010;
    cyc(); #1;
    chk("drop_gid1", gid, 1);
    cyc(); #1;
    chk("drop_beat2", wr, 1);
    cyc();
    valid = 4'b1000;
    #1;
    chk("drop_wr", wr, 0);
    chk("drop_gv", gv, 1);
    cyc(); #1;
    chk("drop_gid3", gid, 3);
    chk("drop_gv3", gv, 1);
    chk("drop_wr3", wr, 1);

    // single requester re-grants itself
    do_rst();
    valid = 4'b0001;
    cyc();
    nwr = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("single_gid", gid, 0);
      chk("single_gv", gv, 1);
      nwr += int'(wr);
      cyc();
    end
    chk("single_writes", nwr, 10);
    valid = '0;
    #1;
    chk("single_drop_wr", wr, 0);
    cyc(); #1;
    chk("single_idle", gv, 0);

    // reset lands on beat 2
    do_rst();
    valid = 4'b0110;
    cyc(); #1;
    chk("mrst_gid", gid, 1);
    chk("mrst_beat1", wr, 1);
    cyc();
    rst = 1'b1;
    #1;
    chk("mrst_wr", wr, 0);
    chk("mrst_ready", ready, 0);
    chk("mrst_gv", gv, 0);
    cyc();
    rst   = 1'b0;
    valid = 4'b0111;
    #1;
    chk("mrst_cnt", dut.r_beat_cnt, 0);
    chk("mrst_last", dut.r_last_id, 3);
    chk("mrst_idle", gv, 0);
    cyc(); #1;
    chk("mrst_prio", gid, 0);
    chk("mrst_gv2", gv, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_wr_arb.md
# sync_fifo_wr_arb

Round-robin write-port arbiter that shares one `sync_fifo` write port among `NUM_REQ` producers. It sits directly in front of the FIFO and drives `wr_en`/`data_in` from the granted requester. It observes the FIFO `full` flag. Grants are burst-locked: a requester keeps the port for up to `MAX_BURST` accepted beats before the grant rotates.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥2.
- `DATA_WIDTH`, 16: word width; must equal the FIFO's `DATA_WIDTH`.
- `MAX_BURST`, 4: maximum accepted beats per grant; must be ≥1.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester data valid.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out `NUM_REQ`: per-requester accept; a beat transfers when `req_valid[i] & req_ready[i]`.
- `fifo_full` in 1: FIFO `full` flag.
- `fifo_wr_en` out 1: to FIFO `wr_en`.
- `fifo_data_in` out `DATA_WIDTH`: to FIFO `data_in`.
- `grant_valid` out 1: a grant is held (state GRANT).
- `grant_id` out `$clog2(NUM_REQ)`: index of the granted requester.

## Operation
- Two-state FSM:
  - IDLE: no grant held.
  - GRANT: grant held by `grant_id`.
- Registers:
  - `state`
  - `grant_id`
  - `last_id` (rotation pointer)
  - `beat_cnt` (width `$clog2(MAX_BURST)+1`)
- Reset values:
  - state IDLE, `grant_id` 0, `last_id` `NUM_REQ-1` (requester 0 has first priority), `beat_cnt` 0.
  - Outputs in reset: `fifo_wr_en` 0, `req_ready` all 0, `grant_valid` 0, `fifo_data_in` 0.
- Pick function: the first index with `req_valid` set, searching `last_id+1, last_id+2, …` modulo `NUM_REQ`.
- IDLE:
  - If any `req_valid` is set, go to GRANT with `grant_id` = pick, `last_id` = pick, `beat_cnt` 0.
  - Otherwise stay in IDLE.
- GRANT, combinational outputs:
  - `req_ready[grant_id]` = `!fifo_full`; all other `req_ready` bits 0.
  - `fifo_wr_en` = `req_valid[grant_id] & !fifo_full`.
  - `fifo_data_in` = `req_data` slice `grant_id`.
- A beat is `fifo_wr_en` high at a clock edge. Each beat increments `beat_cnt`.
- Release: the grant is released at the edge where either condition holds:
  - a beat occurs with `beat_cnt == MAX_BURST-1`, or
  - `req_valid[grant_id]` is low.
- On release, re-pick over `req_valid`, masking the releasing requester only if another requester is valid.
  - If a requester is picked, stay in GRANT with the new `grant_id`, update `last_id`, and clear `beat_cnt`.
  - If none is picked, go to IDLE.
- `fifo_full` high:
  - no beat; the grant is held; `beat_cnt` is frozen.
  - Full cycles never count toward the burst.
  - If `req_valid[grant_id]` drops while full, the normal release rule applies.
- Requester rule: once asserted, `req_valid` with its data stays stable until accepted or until the requester gives up the grant. Dropping `req_valid` is legal and ends that requester's grant.
- Outside GRANT, `fifo_data_in` is 0.
- Reset asserted mid-burst: at the next edge the block returns to reset values. Any unaccepted beat is not written.

## Timing
- Arbitration latency: 1 cycle from first `req_valid` in IDLE to `grant_valid`/`req_ready`.
- Back-to-back grants through re-pick have no bubble cycle.
- Write path from `req_valid`/`fifo_full` to `fifo_wr_en`/`req_ready` is combinational, matching the FIFO sampling `wr_en && !full` at the same edge.
- Peak throughput: 1 beat/cycle while the FIFO is not full.
- Fairness bound: a continuously valid requester waits at most `(NUM_REQ-1)*MAX_BURST` beats plus full-stall cycles.

## Structure
- Shared package `sync_fifo_arb_pkg`:
  - state encoding (IDLE=0, GRANT=1);
  - width helper localparams for `grant_id` and `beat_cnt`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector, `last_id`, mask.
  - Outputs: `found`, `idx`.
  - Instanced once and shared by the IDLE and release paths.

## Test plan
- Reset check: hold `rst` 2 cycles with all `req_valid` high. Required: `req_ready` 0, `fifo_wr_en` 0, `grant_valid` 0. Then release reset. Required: `grant_id` 0 one cycle later.
- Burst lock: all four requesters valid continuously, FIFO never full, `MAX_BURST`=4. Required: `grant_id` sequence 0,0,0,0,1,1,1,1,2,…; 16 writes in 16 cycles after the first grant.
- Full stall: requester 2 granted; assert `fifo_full` for 3 cycles after beat 1. Required:
  - no writes and `req_ready` 0 during those 3 cycles;
  - `beat_cnt` stays 1;
  - after full deasserts, exactly 3 more beats occur, then rotation.
- Early drop: requester 1 drops `req_valid` after 2 beats while requester 3 is valid. Required: `grant_id`=3 on the next cycle with no idle cycle.
- Single requester: only requester 0 valid for 10 beats. Required:
  - re-granted to itself after each 4 beats;
  - 10 writes in 10 cycles;
  - then IDLE when `req_valid` drops.
- Mid-burst reset: assert `rst` during beat 2 of a grant. Required: no `fifo_wr_en` at that edge, all registers at reset values, requester 0 has first priority afterwards.
